// File: rtl/add_nbit_serial.sv
// ---------------------------------------------------------------------------
// add_nbit_serial -- bit-serial N-bit adder with valid/ready handshakes.
//
// One full-adder cell, reused once per clock, produces one sum bit per cycle
// starting at the LSB. A DATA_WIDTH-bit add therefore takes DATA_WIDTH cycles
// in CALC. The finished result is held in DONE until downstream accepts it.
//
// Ports
//   i_clk    : clock, rising-edge active
//   i_rst_n  : synchronous active-low reset
//   i_vld    : operands valid (accepted only in IDLE)
//   o_rdy    : high in IDLE (can accept operands)
//   i_num_a  : operand A
//   i_num_b  : operand B
//   i_cry    : carry into bit 0
//   o_vld    : result valid (DONE)
//   i_rdy    : downstream accepts result
//   o_res    : A + B + i_cry mod 2^DATA_WIDTH
//   o_cry    : carry out of bit DATA_WIDTH-1
//   o_busy   : high while in CALC
//   o_ovf    : signed overflow, only when ADD_SERIAL_OVF_EN is defined
//
// Configuration macro: ADD_SERIAL_OVF_EN adds the o_ovf port and its register.
// ---------------------------------------------------------------------------

module add_01bit_full (
  input  logic i_num_a,
  input  logic i_num_b,
  input  logic i_cry,
  output logic o_res,
  output logic o_cry
);
  assign o_res = i_num_a ^ i_num_b ^ i_cry;
  assign o_cry = (i_num_a & i_num_b) | (i_cry & (i_num_a ^ i_num_b));
endmodule

module add_nbit_serial #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry,
`ifdef ADD_SERIAL_OVF_EN
  output logic                  o_ovf,
`endif
  output logic                  o_busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;     // result shift register, fills MSB-first
  logic                  cry_q, cry_d;   // running carry between bit slices
  logic [DATA_WIDTH-1:0] res_q, res_d;   // delivered result, held between adds
  logic                  cout_q, cout_d; // delivered carry-out
`ifdef ADD_SERIAL_OVF_EN
  logic                  ovf_q, ovf_d;
`endif

  logic                  fa_sum;
  logic                  fa_cry;
  logic                  last_bit;
  logic [DATA_WIDTH:0]   sh_ext;
  logic [DATA_WIDTH-1:0] sh_next;

  add_01bit_full u_fa (
    .i_num_a (a_q[0]),
    .i_num_b (b_q[0]),
    .i_cry   (cry_q),
    .o_res   (fa_sum),
    .o_cry   (fa_cry)
  );

  assign last_bit = (cnt_q == LAST_BIT);
  // Widen before shifting so DATA_WIDTH=1 needs no special-case slice.
  assign sh_ext   = {fa_sum, sh_q};
  assign sh_next  = sh_ext[DATA_WIDTH:1];

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      cry_q   <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      cry_q   <= cry_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
`ifdef ADD_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_vld)    state_d = S_CALC;
      S_CALC:  if (last_bit) state_d = S_DONE;
      S_DONE:  if (i_rdy)    state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    sh_d   = sh_q;
    cry_d  = cry_q;
    res_d  = res_q;
    cout_d = cout_q;
`ifdef ADD_SERIAL_OVF_EN
    ovf_d  = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_vld) begin
          a_d   = i_num_a;
          b_d   = i_num_b;
          cry_d = i_cry;
          cnt_d = '0;
        end
      end
      S_CALC: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        sh_d  = sh_next;
        cry_d = fa_cry;
        cnt_d = cnt_q + CNT_W'(1);
        // Publish the result only once complete so o_res never shows a
        // partially shifted value.
        if (last_bit) begin
          res_d  = sh_next;
          cout_d = fa_cry;
`ifdef ADD_SERIAL_OVF_EN
          // On the MSB slice cry_q is the carry into bit DATA_WIDTH-1.
          ovf_d  = cry_q ^ fa_cry;
`endif
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    o_rdy  = 1'b0;
    o_vld  = 1'b0;
    o_busy = 1'b0;
    case (state_q)
      S_IDLE:  o_rdy  = 1'b1;
      S_CALC:  o_busy = 1'b1;
      S_DONE:  o_vld  = 1'b1;
      default: ;
    endcase
  end

  assign o_res = res_q;
  assign o_cry = cout_q;
`ifdef ADD_SERIAL_OVF_EN
  assign o_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_nbit_serial.sv
// Testbench for add_nbit_serial: an 8-bit instance and a 1-bit instance,
// checked against an arithmetic reference model.
module tb_add_nbit_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld, rdy_in;
  logic [7:0] num_a, num_b;
  logic       cin;
  logic       rdy_out, vld_out, cry_out, busy;
  logic [7:0] res;
  logic       vld1, rdy1_in, a1, b1, c1;
  logic       rdy1_out, vld1_out, res1, cry1_out, busy1;
`ifdef ADD_SERIAL_OVF_EN
  logic       ovf, ovf1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  add_nbit_serial #(.DATA_WIDTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .o_rdy(rdy_out),
    .i_num_a(num_a), .i_num_b(num_b), .i_cry(cin), .o_vld(vld_out),
    .i_rdy(rdy_in), .o_res(res), .o_cry(cry_out),
`ifdef ADD_SERIAL_OVF_EN
    .o_ovf(ovf),
`endif
    .o_busy(busy)
  );

  add_nbit_serial #(.DATA_WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld1), .o_rdy(rdy1_out),
    .i_num_a(a1), .i_num_b(b1), .i_cry(c1), .o_vld(vld1_out),
    .i_rdy(rdy1_in), .o_res(res1), .o_cry(cry1_out),
`ifdef ADD_SERIAL_OVF_EN
    .o_ovf(ovf1),
`endif
    .o_busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cry, res} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
    int unsigned u;
    int sa, sb, s;
    u  = a + b + c;
    sa = (a > 127) ? int'(a) - 256 : int'(a);
    sb = (b > 127) ? int'(b) - 256 : int'(b);
    s  = sa + sb + int'(c);
    model = {((s > 127) || (s < -128)), (u > 255), u[7:0]};
  endfunction

  task automatic start(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    vld = 1'b1; num_a = a; num_b = b; cin = c;
    @(posedge clk); #1;
    vld = 1'b0;
    chk("accept_busy", busy, 1'b1);
  endtask

  // Called right after the accepting edge; checks latency, result and hold.
  task automatic finish(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input int hold, input bit poke);
    logic [9:0] exp;
    int n, busy_cyc;
    bit stable, rdy_low;
    exp = model(a, b, c);
    n = 0; busy_cyc = 1; rdy_low = 1;
    while (!vld_out && n < 20) begin
      if (poke) begin
        vld = 1'b1; num_a = 8'($urandom); num_b = 8'($urandom);
        if (rdy_out) rdy_low = 0;
      end
      @(posedge clk); #1;
      n++;
      if (busy) busy_cyc++;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_busy_cycles"}, busy_cyc, 8);
    chk({tag, "_res"}, res, exp[7:0]);
    chk({tag, "_cry"}, cry_out, exp[8]);
`ifdef ADD_SERIAL_OVF_EN
    chk({tag, "_ovf"}, ovf, exp[9]);
`endif
    stable = 1;
    for (int h = 0; h < hold; h++) begin
      if (poke) begin vld = 1'b1; num_a = 8'($urandom); end
      if (rdy_out) rdy_low = 0;
      @(posedge clk); #1;
      if (!(vld_out === 1'b1 && res === exp[7:0] && cry_out === exp[8])) stable = 0;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, stable, 1'b1);
    if (poke) chk({tag, "_rdy_low_busy"}, rdy_low, 1'b1);
    rdy_in = 1'b1;
    @(posedge clk); #1;
    rdy_in = 1'b0; vld = 1'b0;
    chk({tag, "_vld_drop"}, vld_out, 1'b0);
    chk({tag, "_rdy_back"}, rdy_out, 1'b1);
    chk({tag, "_res_kept"}, res, exp[7:0]);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic rc;
    rst_n = 1'b0; vld = 1'b0; rdy_in = 1'b0; num_a = '0; num_b = '0; cin = 1'b0;
    vld1 = 1'b0; rdy1_in = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", rdy_out, 1'b1);
    chk("rst_vld", vld_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res", res, 8'h00);
    chk("rst_cry", cry_out, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    start(8'h03, 8'h05, 1'b0); finish("add_3_5", 8'h03, 8'h05, 1'b0, 0, 0);
    start(8'hFF, 8'h01, 1'b0); finish("add_ff_01", 8'hFF, 8'h01, 1'b0, 1, 0);
    start(8'hFF, 8'hFF, 1'b1); finish("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 0, 0);
    start(8'h21, 8'h42, 1'b1); finish("hold5_poke", 8'h21, 8'h42, 1'b1, 5, 1);
    start(8'h7F, 8'h01, 1'b0); finish("ovf_pos", 8'h7F, 8'h01, 1'b0, 0, 0);
    start(8'h80, 8'h80, 1'b0); finish("ovf_neg", 8'h80, 8'h80, 1'b0, 0, 0);

    // Reset while processing bit 4 of a calculation.
    start(8'h5A, 8'h33, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_vld", vld_out, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_res", res, 8'h00);
    chk("abort_cry", cry_out, 1'b0);
`ifdef ADD_SERIAL_OVF_EN
    chk("abort_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1; vld = 1'b1; num_a = 8'h10; num_b = 8'h20; cin = 1'b0;
    @(posedge clk); #1;
    vld = 1'b0;
    chk("post_rst_accept", busy, 1'b1);
    finish("post_rst_add", 8'h10, 8'h20, 1'b0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      start(ra, rb, rc);
      finish($sformatf("rand%0d", i), ra, rb, rc, int'($urandom_range(0, 2)), 1'($urandom));
    end

    // 1-bit instance: one CALC cycle per add.
    for (int i = 0; i < 5; i++) begin
      logic [1:0] e;
      int n;
      if (i == 0) begin a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; end
      else begin a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); end
      e = 2'(int'(a1) + int'(b1) + int'(c1));
      @(negedge clk); vld1 = 1'b1;
      @(posedge clk); #1; vld1 = 1'b0;
      chk($sformatf("w1_%0d_busy", i), busy1, 1'b1);
      n = 0;
      while (!vld1_out && n < 5) begin @(posedge clk); #1; n++; end
      chk($sformatf("w1_%0d_latency", i), n, 1);
      chk($sformatf("w1_%0d_res", i), res1, e[0]);
      chk($sformatf("w1_%0d_cry", i), cry1_out, e[1]);
      rdy1_in = 1'b1;
      @(posedge clk); #1; rdy1_in = 1'b0;
      chk($sformatf("w1_%0d_rdy", i), rdy1_out, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/add_nbit_serial.md
ADD_NBIT_SERIAL -- requirements
Module: add_nbit_serial

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the operand/result width in bits; legal range 1..64.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port i_vld  input  1  upstream operands valid.
REQ-005 SHALL have port o_rdy  output  1  block can accept operands.
REQ-006 SHALL have port i_num_a  input  DATA_WIDTH  operand A, unsigned/two's complement.
REQ-007 SHALL have port i_num_b  input  DATA_WIDTH  operand B.
REQ-008 SHALL have port i_cry  input  1  carry-in to bit 0.
REQ-009 SHALL have port o_vld  output  1  result valid.
REQ-010 SHALL have port i_rdy  input  1  downstream accepts result.
REQ-011 SHALL have port o_res  output  DATA_WIDTH  sum A+B+i_cry, modulo 2^DATA_WIDTH.
REQ-012 SHALL have port o_cry  output  1  carry-out of bit DATA_WIDTH-1.
REQ-013 SHALL have port o_busy  output  1  high while the FSM is in CALC.

Function
REQ-014 SHALL compute each sum bit with one instance of add_01bit_full (ports i_num_a, i_num_b, i_cry, o_res, o_cry), one bit per clock, LSB first.
REQ-015 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-016 SHALL drive o_rdy high only in IDLE; o_rdy is a function of state only.
REQ-017 SHALL accept operands on an edge where i_vld && o_rdy: latch i_num_a, i_num_b into shift registers, i_cry into the carry register, clear the bit counter, and move IDLE->CALC.
REQ-018 SHALL, on each CALC edge, shift both operand registers right by one bit, shift the adder o_res into the result register MSB side, load the adder o_cry into the carry register, and increment the counter.
REQ-019 SHALL move CALC->DONE on the edge that processes bit DATA_WIDTH-1, so o_vld rises exactly DATA_WIDTH cycles after the accepting edge.
REQ-020 SHALL hold o_vld high and o_res/o_cry stable in DONE until i_rdy is sampled high, then move DONE->IDLE on that edge.
REQ-021 SHALL ignore i_vld in CALC and DONE; operand inputs are don't-care outside the accepting edge.
REQ-022 SHALL keep o_res and o_cry at their last result values after DONE->IDLE until the next result is complete; they are meaningful only while o_vld is high.
REQ-023 SHALL size the bit counter as max(1, $clog2(DATA_WIDTH)) bits; DATA_WIDTH=1 yields one CALC cycle.
REQ-024 SHALL take at least DATA_WIDTH+2 cycles between consecutive accepts (IDLE, DATA_WIDTH x CALC, >=1 x DONE); no back-to-back overlap.

Reset
REQ-025 SHALL, on any edge with i_rst_n low, force state IDLE, counter 0, operand/result/carry registers 0; outputs: o_rdy 1 (after reset deasserts, i.e. in IDLE), o_vld 0, o_busy 0, o_res 0, o_cry 0.
REQ-026 SHALL abort an in-progress CALC or DONE on reset with no result delivered; i_vld on the first edge after reset release is accepted.

Configuration
REQ-027 SHALL, when macro ADD_SERIAL_OVF_EN is defined, add port o_ovf output 1 = carry into bit DATA_WIDTH-1 XOR carry out of bit DATA_WIDTH-1 (signed overflow), captured during CALC, reset to 0, valid with o_vld.
REQ-028 SHALL, when ADD_SERIAL_OVF_EN is undefined, have no o_ovf port and no extra registers; all other behaviour identical.

Verification (DATA_WIDTH=8)
REQ-029 SHALL cover: A=0x03, B=0x05, cry=0, accept at edge k -> o_vld rises after edge k+8, o_res=0x08, o_cry=0, o_busy high for 8 cycles.
REQ-030 SHALL cover: A=0xFF, B=0x01, cry=0 -> o_res=0x00, o_cry=1; A=0xFF, B=0xFF, cry=1 -> o_res=0xFF, o_cry=1.
REQ-031 SHALL cover: i_rdy held low 5 cycles in DONE -> o_vld and o_res stable all 5 cycles; new i_vld during CALC/DONE ignored (o_rdy=0).
REQ-032 SHALL cover: i_rst_n low for one edge at CALC bit 4 -> o_vld=0, o_busy=0, o_res=0, next accept computes 0x10+0x20=0x30 correctly.
REQ-033 SHALL cover with ADD_SERIAL_OVF_EN: A=0x7F, B=0x01 -> o_res=0x80, o_ovf=1, o_cry=0; A=0x80, B=0x80 -> o_res=0x00, o_ovf=1, o_cry=1.
REQ-034 SHALL cover DATA_WIDTH=1: A=1, B=1, cry=1 -> o_vld one cycle after accept, o_res=1, o_cry=1.
